// File: rtl/systolic_feeder.sv
// Input-skew sequencer for the 2D systolic GEMM array: skews A rows and B columns into a wavefront.
// Optional stall counter enabled by defining SYSTOLIC_FEEDER_STALL_CNT_EN.
module systolic_feeder #(
  parameter int unsigned ROWS     = 16,
  parameter int unsigned COLS     = 16,
  parameter int unsigned DATA_W_P = 16,
  parameter int unsigned K_W      = 16,
  parameter int unsigned PE_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [K_W-1:0]             k_len,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W_P-1:0] a_vec [ROWS],
  input  logic signed [DATA_W_P-1:0] b_vec [COLS],
  output logic                       arr_clear,
  output logic                       arr_valid,
  output logic signed [DATA_W_P-1:0] arr_a [ROWS],
  output logic signed [DATA_W_P-1:0] arr_b [COLS],
  output logic                       tile_done,
  output logic [31:0]                stall_cycles
);

  localparam int unsigned DrainLen = ROWS + COLS - 2 + PE_LAT;
  localparam int unsigned DrainW   = $clog2(DrainLen + 1);

  typedef enum logic [2:0] {StIdle, StClear, StFeed, StDrain, StDone} state_e;

  state_e            state;
  logic [K_W-1:0]    beats_left;
  logic [DrainW-1:0] drain_cnt;
  logic              handshake;
  logic              shifting;

  assign in_ready  = (state == StFeed) && (beats_left != '0);
  assign handshake = in_valid && in_ready;
  assign shifting  = (state == StFeed) || (state == StDrain);

  assign busy      = (state != StIdle);
  assign arr_clear = (state == StClear);
  assign arr_valid = shifting;
  assign tile_done = (state == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      beats_left <= '0;
      drain_cnt  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            beats_left <= k_len;
            state      <= StClear;
          end
        end
        StClear: state <= (beats_left != '0) ? StFeed : StDone;
        StFeed: begin
          if (handshake) begin
            beats_left <= beats_left - 1'b1;
            if (beats_left == K_W'(1)) begin
              state     <= StDrain;
              drain_cnt <= DrainW'(DrainLen);
            end
          end
        end
        StDrain: begin
          drain_cnt <= drain_cnt - 1'b1;
          // <= guards a degenerate zero-length drain configuration
          if (drain_cnt <= DrainW'(1)) state <= StDone;
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  // Lane i of A is i+1 registers deep; bubbles shift in as zeros to keep slices aligned.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
    logic signed [DATA_W_P-1:0] chain [i+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= i; s++) chain[s] <= '0;
      end else if (shifting) begin
        chain[0] <= handshake ? a_vec[i] : '0;
        for (int s = 1; s <= i; s++) chain[s] <= chain[s-1];
      end
    end
    assign arr_a[i] = shifting ? chain[i] : '0;
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_lane
    logic signed [DATA_W_P-1:0] chain [j+1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= j; s++) chain[s] <= '0;
      end else if (shifting) begin
        chain[0] <= handshake ? b_vec[j] : '0;
        for (int s = 1; s <= j; s++) chain[s] <= chain[s-1];
      end
    end
    assign arr_b[j] = shifting ? chain[j] : '0;
  end

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (state == StIdle && start) begin
      stall_q <= '0;
    end else if (in_ready && !in_valid && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (4x4, PE_LAT=1) with a behavioural 4x4 systolic array downstream.
module tb_systolic_feeder;

  localparam int R  = 4;
  localparam int C  = 4;
  localparam int DW = 8;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  localparam int ExpStall = 2;
`else
  localparam int ExpStall = 0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [15:0]          k_len;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] a_vec [R];
  logic signed [DW-1:0] b_vec [C];
  logic                 arr_clear;
  logic                 arr_valid;
  logic signed [DW-1:0] arr_a [R];
  logic signed [DW-1:0] arr_b [C];
  logic                 tile_done;
  logic [31:0]          stall_cycles;

  systolic_feeder #(
    .ROWS(R), .COLS(C), .DATA_W_P(DW), .K_W(16), .PE_LAT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .arr_clear(arr_clear), .arr_valid(arr_valid), .arr_a(arr_a), .arr_b(arr_b),
    .tile_done(tile_done), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Downstream array model: A flows right, B flows down, each PE accumulates on valid.
  logic signed [DW-1:0] ain [R][C];
  logic signed [DW-1:0] bin [R][C];
  logic signed [DW-1:0] pa  [R][C];
  logic signed [DW-1:0] pb  [R][C];
  int                   acc [R][C];

  always_comb begin
    for (int i = 0; i < R; i++) begin
      ain[i][0] = arr_a[i];
      for (int j = 1; j < C; j++) ain[i][j] = pa[i][j-1];
    end
    for (int j = 0; j < C; j++) begin
      bin[0][j] = arr_b[j];
      for (int i = 1; i < R; i++) bin[i][j] = pb[i-1][j];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        if (!rst_n) begin
          pa[i][j] <= '0; pb[i][j] <= '0; acc[i][j] <= 0;
        end else begin
          pa[i][j] <= ain[i][j];
          pb[i][j] <= bin[i][j];
          if (arr_clear) acc[i][j] <= 0;
          else if (arr_valid) acc[i][j] <= acc[i][j] + ain[i][j] * bin[i][j];
        end
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int exp_c [R][C];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_slice(input logic [31:0] av, input logic [31:0] bv);
    for (int i = 0; i < R; i++) a_vec[i] = av[8*i +: 8];
    for (int j = 0; j < C; j++) b_vec[j] = bv[8*j +: 8];
  endtask

  task automatic clear_exp();
    for (int i = 0; i < R; i++) for (int j = 0; j < C; j++) exp_c[i][j] = 0;
  endtask

  task automatic add_exp(input logic [31:0] av, input logic [31:0] bv);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        exp_c[i][j] += int'($signed(av[8*i +: 8])) * int'($signed(bv[8*j +: 8]));
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) begin
        n_cmp++;
        if (acc[i][j] !== exp_c[i][j]) begin
          n_bad++;
          $display("FAIL %s c[%0d][%0d]: got %0d want %0d", tag, i, j, acc[i][j], exp_c[i][j]);
        end
      end
    end
  endtask

  // Advances until tile_done, returning its cycle number or -1 if it never arrives.
  task automatic wait_done(input int limit, output int done_cyc);
    done_cyc = -1;
    while (cyc < limit) begin
      if (tile_done) begin
        done_cyc = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'($urandom);
    in_valid = 1'($urandom);
    k_len    = 16'($urandom);
    for (int i = 0; i < R; i++) a_vec[i] = DW'($urandom);
    for (int j = 0; j < C; j++) b_vec[j] = DW'($urandom);
    #3;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if ({busy, in_ready, arr_clear, arr_valid, tile_done} !== 5'b0) begin
        n_bad++;
        $display("FAIL reset_ctrl: got %b want 00000",
                 {busy, in_ready, arr_clear, arr_valid, tile_done});
      end
      n_cmp++;
      if ({arr_a[0], arr_a[1], arr_a[2], arr_a[3], arr_b[0], arr_b[1], arr_b[2], arr_b[3]}
          !== 64'd0) begin
        n_bad++;
        $display("FAIL reset_data: arr_a/arr_b not all zero");
      end
      n_cmp++;
      if (stall_cycles !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_stall: got %0d want 0", stall_cycles);
      end
      tick();
    end
    start = 1'b0; in_valid = 1'b0; k_len = '0;
    set_slice(32'h0, 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle_busy: got %b want 0", busy);
      end
    end
  endtask

  task automatic test_single_slice(input string tag);
    int done_cyc;
    clear_exp();
    cyc = 0; start = 1'b1; k_len = 16'd1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (arr_clear !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s clear_c1: clear=%b ready=%b want 1 0", tag, arr_clear, in_ready);
    end
    tick();
    n_cmp++;
    if (in_ready !== 1'b1 || arr_valid !== 1'b1 || arr_clear !== 1'b0) begin
      n_bad++;
      $display("FAIL %s feed_c2: ready=%b valid=%b clear=%b want 1 1 0",
               tag, in_ready, arr_valid, arr_clear);
    end
    in_valid = 1'b1;
    set_slice(32'h04030201, 32'h08070605);
    add_exp(32'h04030201, 32'h08070605);
    tick();
    in_valid = 1'b0;
    set_slice(32'h0, 32'h0);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s ready_after_last: got %b want 0", tag, in_ready);
    end
    tick(); tick();
    n_cmp++;
    if (arr_b[2] !== 8'sd7) begin
      n_bad++;
      $display("FAIL %s arr_b2_c5: got %0d want 7", tag, arr_b[2]);
    end
    tick();
    n_cmp++;
    if (arr_a[3] !== 8'sd4) begin
      n_bad++;
      $display("FAIL %s arr_a3_c6: got %0d want 4", tag, arr_a[3]);
    end
    wait_done(40, done_cyc);
    n_cmp++;
    if (done_cyc !== 10) begin
      n_bad++;
      $display("FAIL %s done_cycle: got %0d want 10", tag, done_cyc);
    end
    check_results(tag);
    tick();
  endtask

  task automatic test_stalled_stream();
    int done_cyc;
    clear_exp();
    cyc = 0; start = 1'b1; k_len = 16'd3;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1;
    set_slice(32'hFC03FE01, 32'h080706FB);
    add_exp(32'hFC03FE01, 32'h080706FB);
    tick();
    in_valid = 1'b0;
    set_slice(32'h0, 32'h0);
    n_cmp++;
    if (arr_a[0] !== 8'sd1) begin
      n_bad++;
      $display("FAIL stall arr_a0_c3: got %0d want 1", arr_a[0]);
    end
    tick();
    n_cmp++;
    if (arr_a[0] !== 8'sd0 || arr_b[0] !== 8'sd0) begin
      n_bad++;
      $display("FAIL stall bubble_c4: a0=%0d b0=%0d want 0 0", arr_a[0], arr_b[0]);
    end
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL stall ready_c5: got %b want 1", in_ready);
    end
    in_valid = 1'b1;
    set_slice(32'h28E2140A, 32'hFB04FD02);
    add_exp(32'h28E2140A, 32'hFB04FD02);
    tick();
    n_cmp++;
    if (arr_a[0] !== 8'sd10) begin
      n_bad++;
      $display("FAIL stall arr_a0_c6: got %0d want 10", arr_a[0]);
    end
    set_slice(32'h07F907F9, 32'hFFFF0101);
    add_exp(32'h07F907F9, 32'hFFFF0101);
    tick();
    in_valid = 1'b0;
    set_slice(32'h0, 32'h0);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL stall ready_c7: got %b want 0", in_ready);
    end
    wait_done(40, done_cyc);
    n_cmp++;
    if (done_cyc !== 14) begin
      n_bad++;
      $display("FAIL stall done_cycle: got %0d want 14", done_cyc);
    end
    check_results("stall");
    tick();
    n_cmp++;
    if (stall_cycles !== 32'(ExpStall)) begin
      n_bad++;
      $display("FAIL stall count: got %0d want %0d", stall_cycles, ExpStall);
    end
  endtask

  task automatic test_zero_len();
    cyc = 0; start = 1'b1; k_len = 16'd0;
    tick();
    start = 1'b0;
    n_cmp++;
    if (arr_clear !== 1'b1 || arr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL zero c1: clear=%b valid=%b want 1 0", arr_clear, arr_valid);
    end
    tick();
    n_cmp++;
    if (tile_done !== 1'b1 || arr_valid !== 1'b0 || arr_clear !== 1'b0) begin
      n_bad++;
      $display("FAIL zero c2: done=%b valid=%b clear=%b want 1 0 0",
               tile_done, arr_valid, arr_clear);
    end
    n_cmp++;
    if (stall_cycles !== 32'd0) begin
      n_bad++;
      $display("FAIL zero stall_cleared: got %0d want 0", stall_cycles);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || tile_done !== 1'b0) begin
      n_bad++;
      $display("FAIL zero c3: busy=%b done=%b want 0 0", busy, tile_done);
    end
  endtask

  task automatic test_start_in_feed();
    int done_cyc;
    clear_exp();
    cyc = 0; start = 1'b1; k_len = 16'd2;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1;
    set_slice(32'h01010101, 32'h02020202);
    add_exp(32'h01010101, 32'h02020202);
    tick();
    start = 1'b1; k_len = 16'd9;
    set_slice(32'h05FB0300, 32'hFF010203);
    add_exp(32'h05FB0300, 32'hFF010203);
    tick();
    in_valid = 1'b0;
    set_slice(32'h0, 32'h0);
    n_cmp++;
    if (in_ready !== 1'b0 || arr_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_start c4: ready=%b valid=%b want 0 1", in_ready, arr_valid);
    end
    tick();
    start = 1'b0;
    wait_done(40, done_cyc);
    n_cmp++;
    if (done_cyc !== 11) begin
      n_bad++;
      $display("FAIL ignore_start done_cycle: got %0d want 11", done_cyc);
    end
    check_results("ignore_start");
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL ignore_start idle_after: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_drain();
    int seen;
    cyc = 0; start = 1'b1; k_len = 16'd1;
    tick();
    start = 1'b0;
    tick();
    in_valid = 1'b1;
    set_slice(32'h04030201, 32'h08070605);
    tick();
    in_valid = 1'b0;
    set_slice(32'h0, 32'h0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, arr_valid, tile_done, in_ready} !== 4'b0) begin
      n_bad++;
      $display("FAIL mid_reset ctrl: got %b want 0000", {busy, arr_valid, tile_done, in_ready});
    end
    n_cmp++;
    if ({arr_a[0], arr_a[1], arr_a[2], arr_a[3], arr_b[0], arr_b[1], arr_b[2], arr_b[3]}
        !== 64'd0) begin
      n_bad++;
      $display("FAIL mid_reset data: arr_a/arr_b not all zero");
    end
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (tile_done) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL mid_reset no_done: got %0d pulses want 0", seen);
    end
    test_single_slice("after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_slice("single");
    test_stalled_stream();
    test_zero_len();
    test_start_in_feed();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Input-skew sequencer placed directly upstream of the 2D systolic GEMM array. Per GEMM tile it accepts K slices, each an A column vector (ROWS elements) plus a B row vector (COLS elements), over a valid/ready handshake. It delays row i of A by i cycles and column j of B by j cycles, which forms the diagonal wavefront the array needs. It also drives the array's clear and valid controls and pulses `tile_done` once every PE accumulator holds its final value.

## Interface
Parameters:
- `ROWS`, 16: array rows; number of A lanes.
- `COLS`, 16: array columns; number of B lanes.
- `DATA_W_P`, `DATA_W`: signed operand width.
- `K_W`, 16: width of `k_len`.
- `PE_LAT`, 1: PE accumulate latency, in cycles, after operands arrive.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a tile; sampled only in IDLE.
- `k_len`  in  K_W  slices in the tile; captured with `start`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `in_valid`  in  1  slice offered.
- `in_ready`  out  1  slice accepted when `in_valid` and `in_ready` are both high.
- `a_vec`  in  signed DATA_W_P × [ROWS]  A column of the current slice.
- `b_vec`  in  signed DATA_W_P × [COLS]  B row of the current slice.
- `arr_clear`  out  1  to the array's `clear_all`.
- `arr_valid`  out  1  to the array's `valid_in`.
- `arr_a`  out  signed DATA_W_P × [ROWS]  to the array's `a_in`.
- `arr_b`  out  signed DATA_W_P × [COLS]  to the array's `b_in`.
- `tile_done`  out  1  one-cycle pulse; array results are final.
- `stall_cycles`  out  32  FEED cycles with no handshake (see Configuration).

## Operation
State machine: IDLE → CLEAR → FEED → DRAIN → DONE → IDLE.
- **IDLE**
  - If `start`: capture `k_len` into `beats_left` and go to CLEAR.
  - Otherwise stay.
- **CLEAR**
  - Drive `arr_clear`=1 for exactly 1 cycle.
  - Go to FEED if `beats_left`≠0, else go to DONE. With `k_len`=0 the result is all-zero.
- **FEED**
  - `in_ready` = (`beats_left`≠0).
  - On each handshake, decrement `beats_left`.
  - The cycle after the last handshake, go to DRAIN and load `drain_cnt` = ROWS+COLS−2+PE_LAT.
- **DRAIN**
  - Decrement `drain_cnt` every cycle.
  - When it reaches 1, go to DONE.
- **DONE**
  - `tile_done`=1 for 1 cycle, then go to IDLE.

Skew datapath:
- Lane i of A is a shift chain of depth i+1; lane j of B is a chain of depth j+1.
- Every chain shifts every cycle while in FEED or DRAIN.
- The chain head loads `a_vec[i]`/`b_vec[j]` on a handshake, and loads 0 otherwise (bubble or DRAIN).
- Zero injection keeps A and B slices aligned across stalls. Zero products add nothing to the accumulators.
- Chains hold their value, and `arr_a`/`arr_b` are forced to 0, in IDLE, CLEAR and DONE.

Control outputs:
- `arr_valid` = state ∈ {FEED, DRAIN}.
- `start` asserted while busy is ignored.
- `in_ready` is 0 outside FEED.
- No arithmetic is performed; operands pass through unmodified and sign-preserved.

## Timing
- Reset values: every output is 0 and every chain register is 0; state = IDLE; `stall_cycles` = 0. Reset mid-tile aborts immediately and no `tile_done` is produced.
- With `start` sampled in cycle 0:
  - `arr_clear`=1 in cycle 1.
  - FEED begins in cycle 2, with `in_ready`=1 from cycle 2.
- A slice accepted in cycle t appears on `arr_a[i]` in cycle t+1+i and on `arr_b[j]` in cycle t+1+j.
- With the last handshake in cycle t_L:
  - DRAIN covers cycles t_L+1 … t_L+D, where D = ROWS+COLS−2+PE_LAT.
  - `tile_done` fires in cycle t_L+D+1.
- `in_ready` is combinational from state and `beats_left` only; it does not depend on `in_valid`.

## Configuration
- `SYSTOLIC_FEEDER_STALL_CNT_EN`
  - Defined: `stall_cycles` counts FEED cycles in which `in_valid`=0 while `in_ready`=1. It clears on entry to CLEAR, holds its value after DONE, and saturates at 2^32−1.
  - Undefined: `stall_cycles` is tied to 0 and the counter logic is not built.

## Test plan
All scenarios use ROWS=COLS=4 and PE_LAT=1, so D=7.
- Reset: `rst_n`=0 with random inputs → all outputs 0 and `busy`=0. After release, `busy` stays 0 until `start`.
- Single slice: `k_len`=1, a=[1,2,3,4], b=[5,6,7,8], accepted in cycle 2 →
  - `arr_a[3]`=4 in cycle 6; `arr_b[2]`=7 in cycle 5.
  - `tile_done` in cycle 10.
  - The downstream array yields c[i][j] = a[i]·b[j].
- Stalled stream: `k_len`=3 with `in_valid` low for 2 cycles between slices →
  - Zeros are inserted in every lane and the array result equals the unstalled result.
  - `stall_cycles`=2 with the macro defined, 0 without it.
- k_len=0: `start` → `arr_clear` in cycle 1, `tile_done` in cycle 2, and no cycle has `arr_valid`=1.
- `start` pulsed during FEED → ignored; beat count and `tile_done` timing are unchanged.
- Reset asserted mid-DRAIN → outputs are 0 immediately, no `tile_done`, and the next `start` runs a clean tile.
